// File: rtl/alu_pkg.sv
// Shared opcode encodings, opcode enum and FSM state type for the alu_mdu execute stage.
// Opcodes 14-15 are reserved; 10-13 are served by the iterative engine when ALU_MDU_EN is defined.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;
  localparam logic [3:0] OP_RSV14 = 4'd14;
  localparam logic [3:0] OP_RSV15 = 4'd15;

  typedef enum logic [3:0] {
    ALU_ADD   = OP_ADD,
    ALU_SUB   = OP_SUB,
    ALU_AND   = OP_AND,
    ALU_OR    = OP_OR,
    ALU_XOR   = OP_XOR,
    ALU_SLL   = OP_SLL,
    ALU_SRL   = OP_SRL,
    ALU_SRA   = OP_SRA,
    ALU_SLT   = OP_SLT,
    ALU_SLTU  = OP_SLTU,
    ALU_MUL   = OP_MUL,
    ALU_MULHU = OP_MULHU,
    ALU_DIVU  = OP_DIVU,
    ALU_REMU  = OP_REMU,
    ALU_RSV14 = OP_RSV14,
    ALU_RSV15 = OP_RSV15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_mdu_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine, one step per cycle.
// Latency: DATA_WIDTH cycles after start; divide-by-zero answers combinationally with start.
// Backpressure: none; the caller holds the result, start is only legal while busy is low.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  logic                    busy_q, busy_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2*DATA_WIDTH-1:0] acc_q, acc_d, acc_nxt;
  logic [DATA_WIDTH-1:0]   opnd_q, opnd_d;
  logic                    div_q, div_d;
  logic                    hi_q, hi_d;

  logic                    op_div, op_hi, bypass, last;
  logic [DATA_WIDTH:0]     add_sum, div_top, div_trial;

  assign op_div = (op == OP_DIVU) || (op == OP_REMU);
  assign op_hi  = (op == OP_MULHU) || (op == OP_REMU);
  assign bypass = start && op_div && (b == '0);
  assign last   = busy_q && (cnt_q == LAST);

  // Multiply: acc = {partial product high, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits becoming quotient}.
  assign add_sum   = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]}
                   + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_top   = acc_q[2*DATA_WIDTH-1:DATA_WIDTH-1];
  assign div_trial = div_top - {1'b0, opnd_q};

  always_comb begin
    if (div_q) begin
      if (!div_trial[DATA_WIDTH]) begin
        acc_nxt = {div_trial[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = {div_top[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt = {add_sum, acc_q[DATA_WIDTH-1:1]};
    end
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    hi_d   = hi_q;
    if (start && !bypass) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      div_d  = op_div;
      hi_d   = op_hi;
      if (op_div) begin
        acc_d  = {{DATA_WIDTH{1'b0}}, a};
        opnd_d = b;
      end else begin
        acc_d  = {{DATA_WIDTH{1'b0}}, b};
        opnd_d = a;
      end
    end else if (busy_q) begin
      acc_d = acc_nxt;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      hi_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      hi_q   <= hi_d;
    end
  end

  assign busy = busy_q;
  assign done = bypass || last;

  // The final step's value is handed out directly so the caller captures on that same edge.
  always_comb begin
    if (bypass) begin
      result = (op == OP_REMU) ? a : '1;
    end else if (hi_q) begin
      result = acc_nxt[2*DATA_WIDTH-1:DATA_WIDTH];
    end else begin
      result = acc_nxt[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with immediate mux, flags and (with ALU_MDU_EN) an iterative mul/div engine.
// Latency: 1 edge for single-cycle ops and divide-by-zero, DATA_WIDTH+1 edges for mul/div.
// Backpressure: result and flags held in DONE until out_ready; in_ready low in BUSY and DONE.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] ALUop1,
  input  logic [DATA_WIDTH-1:0] regop2,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  input  logic                  ALUsrc,
  input  logic [3:0]            ALUctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUout,
  output logic                  EQ,
  output logic                  LT,
  output logic                  LTU
);

  localparam int SH_W = $clog2(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] alu_out_q, alu_out_d;
  logic                  eq_q, eq_d, lt_q, lt_d, ltu_q, ltu_d;

  logic [DATA_WIDTH-1:0] op_b, alu_res;
  logic [SH_W-1:0]       shamt;
  logic                  eq_c, lt_c, ltu_c, flag_en;

  assign op_b  = ALUsrc ? ImmOp : regop2;
  assign shamt = op_b[SH_W-1:0];
  assign eq_c  = (ALUop1 == op_b);
  assign lt_c  = ($signed(ALUop1) < $signed(op_b));
  assign ltu_c = (ALUop1 < op_b);

`ifdef ALU_MDU_EN
  logic                  mdu_start, mdu_busy, mdu_done;
  logic [DATA_WIDTH-1:0] mdu_result;

  assign flag_en   = !((ALUctrl == OP_RSV14) || (ALUctrl == OP_RSV15));
  assign mdu_start = (state_q == IDLE) && in_valid && is_mdu_op(ALUctrl);

  mdu_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mdu (
    .clk   (clk),
    .rst   (rst),
    .start (mdu_start),
    .op    (ALUctrl),
    .a     (ALUop1),
    .b     (op_b),
    .busy  (mdu_busy),
    .done  (mdu_done),
    .result(mdu_result)
  );
`else
  assign flag_en = !((ALUctrl == OP_RSV14) || (ALUctrl == OP_RSV15) || is_mdu_op(ALUctrl));
`endif

  always_comb begin
    alu_res = '0;
    case (alu_op_e'(ALUctrl))
      ALU_ADD:  alu_res = ALUop1 + op_b;
      ALU_SUB:  alu_res = ALUop1 - op_b;
      ALU_AND:  alu_res = ALUop1 & op_b;
      ALU_OR:   alu_res = ALUop1 | op_b;
      ALU_XOR:  alu_res = ALUop1 ^ op_b;
      ALU_SLL:  alu_res = ALUop1 << shamt;
      ALU_SRL:  alu_res = ALUop1 >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(ALUop1) >>> shamt);
      ALU_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, lt_c};
      ALU_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, ltu_c};
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    alu_out_d = alu_out_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    ltu_d     = ltu_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          eq_d  = flag_en & eq_c;
          lt_d  = flag_en & lt_c;
          ltu_d = flag_en & ltu_c;
`ifdef ALU_MDU_EN
          if (mdu_start) begin
            if (mdu_done) begin
              alu_out_d = mdu_result;
              state_d   = DONE;
            end else begin
              state_d = BUSY;
            end
          end else begin
            alu_out_d = alu_res;
            state_d   = DONE;
          end
`else
          alu_out_d = alu_res;
          state_d   = DONE;
`endif
        end
      end
      BUSY: begin
`ifdef ALU_MDU_EN
        if (mdu_busy && mdu_done) begin
          alu_out_d = mdu_result;
          state_d   = DONE;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      alu_out_q <= '0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      ltu_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_out_q <= alu_out_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
      ltu_q     <= ltu_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign ALUout    = alu_out_q;
  assign EQ        = eq_q;
  assign LT        = lt_q;
  assign LTU       = ltu_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu (DATA_WIDTH=32); expectations follow ALU_MDU_EN when it is defined.
module tb_alu_mdu;
  import alu_pkg::*;

`ifdef ALU_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif
  localparam int MDU_LAT = MDU_EN ? 33 : 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] ALUop1, regop2, ImmOp;
  logic        ALUsrc;
  logic [3:0]  ALUctrl;
  logic        out_valid, out_ready;
  logic [31:0] ALUout;
  logic        EQ, LT, LTU;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  bit ir_seen;

  always #5 clk = ~clk;

  alu_mdu #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUop1(ALUop1), .regop2(regop2), .ImmOp(ImmOp), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl),
    .out_valid(out_valid), .out_ready(out_ready), .ALUout(ALUout),
    .EQ(EQ), .LT(LT), .LTU(LTU)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one op at a falling edge, then count edges until out_valid (bounded).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rb,
                       input logic [31:0] imm, input logic src);
    @(negedge clk);
    in_valid = 1'b1; ALUctrl = op; ALUop1 = a; regop2 = rb; ImmOp = imm; ALUsrc = src;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    ir_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ir_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " drained"}, out_valid, 1'b0);
  endtask

  task automatic op_chk(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] rb, input logic [31:0] imm, input logic src,
                        input logic [31:0] exp_res, input logic [2:0] exp_flags, input int exp_lat);
    issue(op, a, rb, imm, src);
    chk({tag, " result"}, ALUout, exp_res);
    chk({tag, " flags"}, {EQ, LT, LTU}, exp_flags);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " in_ready busy"}, ir_seen, 1'b0);
    chk({tag, " in_ready done"}, in_ready, 1'b0);
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] rb, input logic [31:0] imm, input logic src,
                     input logic [31:0] exp_res, input logic [2:0] exp_flags, input int exp_lat);
    op_chk(tag, op, a, rb, imm, src, exp_res, exp_flags, exp_lat);
    take(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ALUop1 = '0; regop2 = '0; ImmOp = '0; ALUsrc = 1'b0; ALUctrl = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset ALUout", ALUout, 32'h0);
    chk("reset flags", {EQ, LT, LTU}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", in_ready, 1'b1);

    // Single-cycle datapath; flags are {EQ,LT,LTU}
    run("add",      OP_ADD,  32'd5,        32'd7,        32'd999, 1'b0, 32'd12,       3'b011, 1);
    run("sub imm",  OP_SUB,  32'd9,        32'd3,        32'd9,   1'b1, 32'd0,        3'b100, 1);
    run("sra",      OP_SRA,  32'h8000_0000, 32'd4,       32'd0,   1'b0, 32'hF800_0000, 3'b010, 1);
    run("sra hi",   OP_SRA,  32'h8000_0000, 32'h24,      32'd0,   1'b0, 32'hF800_0000, 3'b010, 1);
    run("slt",      OP_SLT,  32'hFFFF_FFFF, 32'd1,       32'd0,   1'b0, 32'd1,        3'b010, 1);
    run("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'd1,       32'd0,   1'b0, 32'd0,        3'b010, 1);
    run("sll",      OP_SLL,  32'd1,        32'd31,       32'd0,   1'b0, 32'h8000_0000, 3'b011, 1);
    run("srl",      OP_SRL,  32'h8000_0000, 32'd0,       32'd31,  1'b1, 32'd1,        3'b010, 1);
    run("and",      OP_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 1'b0, 32'h00F0_000F, 3'b010, 1);
    run("or",       OP_OR,   32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 1'b0, 32'hFFF0_0FFF, 3'b010, 1);
    run("xor",      OP_XOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 1'b0, 32'hFF00_0FF0, 3'b010, 1);
    run("add wrap", OP_ADD,  32'hFFFF_FFFF, 32'd1,       32'd0,   1'b0, 32'd0,        3'b010, 1);
    run("rsv14",    OP_RSV14, 32'd5,       32'd5,        32'd0,   1'b0, 32'd0,        3'b000, 1);

    // Multiply / divide (reserved behaviour when the engine is left out)
    run("mul",    OP_MUL,   32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 32'd0,
        MDU_EN ? 3'b100 : 3'b000, MDU_LAT);
    run("mulhu",  OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, MDU_EN ? 32'd1 : 32'd0,
        MDU_EN ? 3'b100 : 3'b000, MDU_LAT);
    run("mul max",   OP_MUL,   32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b1, MDU_EN ? 32'd1 : 32'd0,
        MDU_EN ? 3'b100 : 3'b000, MDU_LAT);
    run("mulhu max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0,
        MDU_EN ? 32'hFFFF_FFFE : 32'd0, MDU_EN ? 3'b100 : 3'b000, MDU_LAT);
    run("divu",   OP_DIVU,  32'd100, 32'd7, 32'd0, 1'b0, MDU_EN ? 32'd14 : 32'd0, 3'b000, MDU_LAT);
    run("remu",   OP_REMU,  32'd100, 32'd7, 32'd0, 1'b0, MDU_EN ? 32'd2 : 32'd0,  3'b000, MDU_LAT);
    run("divu by1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, MDU_EN ? 32'hFFFF_FFFF : 32'd0,
        MDU_EN ? 3'b010 : 3'b000, MDU_LAT);
    run("divu 0", OP_DIVU,  32'h55, 32'd0, 32'd0, 1'b0, MDU_EN ? 32'hFFFF_FFFF : 32'd0, 3'b000, 1);
    run("remu 0", OP_REMU,  32'h55, 32'd0, 32'd0, 1'b0, MDU_EN ? 32'h55 : 32'd0, 3'b000, 1);

    // Hold in DONE with a competing offer that must be ignored
    op_chk("hold", OP_ADD, 32'd3, 32'd4, 32'd0, 1'b0, 32'd7, 3'b011, 1);
    @(negedge clk);
    in_valid = 1'b1; ALUctrl = OP_SUB; ALUop1 = 32'd50; regop2 = 32'd1; ALUsrc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold ALUout", ALUout, 32'd7);
      chk("hold out_valid", out_valid, 1'b1);
      chk("hold in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    take("hold");
    chk("after take in_ready", in_ready, 1'b1);
    run("post hold", OP_ADD, 32'd10, 32'd20, 32'd0, 1'b0, 32'd30, 3'b011, 1);

    // Reset while a result waits in DONE
    op_chk("rst done", OP_ADD, 32'd3, 32'd4, 32'd0, 1'b0, 32'd7, 3'b011, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst done out_valid", out_valid, 1'b0);
    chk("rst done ALUout", ALUout, 32'd0);
    chk("rst done flags", {EQ, LT, LTU}, 3'b000);
    @(negedge clk);
    rst = 1'b0;

`ifdef ALU_MDU_EN
    // Reset in the middle of a multiply; the in-flight op must vanish
    @(negedge clk);
    in_valid = 1'b1; ALUctrl = OP_MUL; ALUop1 = 32'd3; regop2 = 32'd3; ALUsrc = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("busy in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst busy out_valid", out_valid, 1'b0);
    chk("rst busy ALUout", ALUout, 32'd0);
    chk("rst busy in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("rst busy discarded", out_valid, 1'b0);
`endif

    run("post rst", OP_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 32'd3, 3'b011, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
